// File: rtl/fft16_pkg.sv
// Shared constants, FSM state type and the load-side digit-reversal mapping
// for the 16-point radix-4 FFT controller.
package fft16_pkg;

    localparam int DW  = 17;
    localparam int CW  = 2 * DW;
    localparam int NPT = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CALC   = 2'd1,
        UNLOAD = 2'd2
    } ctrlState_t;

    // Base-4 digit swap: sample n lands where the first radix-4 pass expects it.
    function automatic logic [3:0] digitRev(input logic [3:0] n);
        return {n[1:0], n[3:2]};
    endfunction

endpackage

// File: rtl/fft16_sample_ram.sv
// 16 x 34 sample register file: one load write port, four butterfly lanes
// (combinational read, synchronous write) and one unload read port.
module fft16_sample_ram
    import fft16_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_ldWe,
    input  logic [3:0]        i_ldAddr,
    input  logic [CW-1:0]     i_ldData,
    input  logic              i_bfWe,
    input  logic [15:0]       i_bfAddr,
    input  logic [4*CW-1:0]   i_bfWdata,
    output logic [4*CW-1:0]   o_bfRdata,
    input  logic [3:0]        i_rdAddr,
    output logic [CW-1:0]     o_rdData
);

    logic [CW-1:0] r_mem [NPT];

    // Contents are deliberately not reset; every frame overwrites all entries.
    always_ff @(posedge i_clk) begin
        if (i_ldWe) begin
            r_mem[i_ldAddr] <= i_ldData;
        end
        if (i_bfWe) begin
            for (int j = 0; j < 4; j++) begin
                r_mem[i_bfAddr[4*j +: 4]] <= i_bfWdata[CW*j +: CW];
            end
        end
    end

    always_comb begin
        o_bfRdata = '0;
        for (int j = 0; j < 4; j++) begin
            o_bfRdata[CW*j +: CW] = r_mem[i_bfAddr[4*j +: 4]];
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/fft16_ctrl.sv
// Frame controller for a 16-point radix-4 FFT: loads samples in digit-reversed
// order, runs 8 in-place butterflies through an external unit, then unloads.
module fft16_ctrl #(
    parameter int DW = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DW-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DW-1:0]     out_data,
    output logic [8*DW-1:0]     bf_in,
    output logic [2:0]          bf_rot,
    input  logic [8*DW-1:0]     bf_out,
    output logic                busy,
    output logic                frame_done
);

    import fft16_pkg::*;

    ctrlState_t    r_state;
    ctrlState_t    w_nextState;
    logic [3:0]    r_loadCnt;
    logic [2:0]    r_bfCnt;
    logic [3:0]    r_outCnt;

    logic          w_ldWe;
    logic          w_bfWe;
    logic          w_outAccept;
    logic [15:0]   w_laneAddr;
    logic [4*CW-1:0] w_bfRdata;
    logic [CW-1:0] w_rdData;

    assign w_ldWe      = (r_state == LOAD) && in_valid;
    assign w_bfWe      = (r_state == CALC);
    assign w_outAccept = (r_state == UNLOAD) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            LOAD:    if (w_ldWe && (r_loadCnt == 4'd15)) w_nextState = CALC;
            CALC:    if (r_bfCnt == 3'd7) w_nextState = UNLOAD;
            UNLOAD:  if (w_outAccept && (r_outCnt == 4'd15)) w_nextState = LOAD;
            default: w_nextState = LOAD;
        endcase
    end

    // Counters wrap to zero on their final step, so each phase hands over clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loadCnt <= 4'd0;
            r_bfCnt   <= 3'd0;
            r_outCnt  <= 4'd0;
        end else begin
            if (w_ldWe) begin
                r_loadCnt <= r_loadCnt + 4'd1;
            end
            if (w_bfWe) begin
                r_bfCnt <= r_bfCnt + 3'd1;
            end
            if (w_outAccept) begin
                r_outCnt <= r_outCnt + 4'd1;
            end
        end
    end

    // Stage 0 groups contiguous quads {4k+j}; stage 1 strides by 4 {k+4j}.
    always_comb begin
        w_laneAddr = '0;
        for (int j = 0; j < 4; j++) begin
            if (!r_bfCnt[2]) begin
                w_laneAddr[4*j +: 4] = {r_bfCnt[1:0], 2'(j)};
            end else begin
                w_laneAddr[4*j +: 4] = {2'(j), r_bfCnt[1:0]};
            end
        end
    end

    fft16_sample_ram u_ram (
        .i_clk     (clk),
        .i_ldWe    (w_ldWe),
        .i_ldAddr  (digitRev(r_loadCnt)),
        .i_ldData  (in_data),
        .i_bfWe    (w_bfWe),
        .i_bfAddr  (w_laneAddr),
        .i_bfWdata (bf_out),
        .o_bfRdata (w_bfRdata),
        .i_rdAddr  (r_outCnt),
        .o_rdData  (w_rdData)
    );

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        bf_in      = '0;
        bf_rot     = 3'd0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (r_state)
            LOAD: begin
                in_ready = 1'b1;
            end
            CALC: begin
                busy   = 1'b1;
                bf_in  = w_bfRdata;
                bf_rot = r_bfCnt;
            end
            UNLOAD: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_data   = w_rdData;
                frame_done = w_outAccept && (r_outCnt == 4'd15);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fft16_ctrl.sv
// Self-checking bench for fft16_ctrl: a selectable butterfly stub, an
// array-based reference of the load/calc/unload rules, and literal spot checks.
module tb_fft16_ctrl;

    localparam int DW = 17;
    localparam int CW = 34;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [CW-1:0]   out_data;
    logic [4*CW-1:0] bf_in;
    logic [4*CW-1:0] bf_out;
    logic [2:0]      bf_rot;
    logic            busy;
    logic            frame_done;

    int checks = 0;
    int errors = 0;
    int stubMode = 0;
    int readyMode = 0;

    fft16_ctrl #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bf_in      (bf_in),
        .bf_rot     (bf_rot),
        .bf_out     (bf_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [4*CW-1:0] act, input logic [4*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Twiddles in Q14: W16^m = cos - j*sin, m = 0..9.
    function automatic int cosQ(input int m);
        case (m)
            0: return 16384;  1: return 15137;  2: return 11585;  3: return 6270;
            4: return 0;      5: return -6270;  6: return -11585; 7: return -15137;
            8: return -16384; default: return -15137;
        endcase
    endfunction

    function automatic int sinQ(input int m);
        case (m)
            0: return 0;      1: return 6270;   2: return 11585;  3: return 15137;
            4: return 16384;  5: return 15137;  6: return 11585;  7: return 6270;
            8: return 0;      default: return -6270;
        endcase
    endfunction

    // mode 0 identity, 1 radix-4 DIT butterfly, 2 lane/rotation tag adder.
    function automatic logic [4*CW-1:0] stubFn(input logic [4*CW-1:0] lanes, input logic [2:0] rot, input int mode);
        logic [4*CW-1:0] res;
        int ar[4], ai[4], xr[4], xi[4];
        int r, m;
        longint pr, pi;
        r = int'(rot);
        for (int j = 0; j < 4; j++) begin
            ar[j] = int'($signed(lanes[CW*j+DW +: DW]));
            ai[j] = int'($signed(lanes[CW*j +: DW]));
            xr[j] = ar[j];
            xi[j] = ai[j];
        end
        if (mode == 2) begin
            for (int j = 0; j < 4; j++) begin
                xr[j] = ar[j] + 1 + j + 4*r;
                xi[j] = ai[j] + 8*r + j;
            end
        end else if (mode == 1) begin
            if (rot[2]) begin
                for (int j = 1; j < 4; j++) begin
                    m  = j * int'(rot[1:0]);
                    pr = (longint'(ar[j]) * cosQ(m) + longint'(ai[j]) * sinQ(m)) >>> 14;
                    pi = (longint'(ai[j]) * cosQ(m) - longint'(ar[j]) * sinQ(m)) >>> 14;
                    ar[j] = int'(pr);
                    ai[j] = int'(pi);
                end
            end
            xr[0] = ar[0] + ar[1] + ar[2] + ar[3];
            xi[0] = ai[0] + ai[1] + ai[2] + ai[3];
            xr[1] = ar[0] + ai[1] - ar[2] - ai[3];
            xi[1] = ai[0] - ar[1] - ai[2] + ar[3];
            xr[2] = ar[0] - ar[1] + ar[2] - ar[3];
            xi[2] = ai[0] - ai[1] + ai[2] - ai[3];
            xr[3] = ar[0] - ai[1] - ar[2] + ai[3];
            xi[3] = ai[0] + ar[1] - ai[2] - ar[3];
        end
        res = '0;
        for (int j = 0; j < 4; j++) begin
            res[CW*j+DW +: DW] = 17'(xr[j]);
            res[CW*j +: DW]    = 17'(xi[j]);
        end
        return res;
    endfunction

    assign bf_out = stubFn(bf_in, bf_rot, stubMode);

    function automatic int laneAddr(input int c, input int j);
        return (c < 4) ? (4*c + j) : ((c - 4) + 4*j);
    endfunction

    // Reference model: phase/count bookkeeping plus a 16-entry sample array.
    logic [CW-1:0]   mMem [16];
    int mPhase = 0, mLoadN = 0, mCalcN = 0, mOutN = 0;
    int cyc = 0, lastAcceptCyc = 0, lastDoneCyc = 0, donePulses = 0;
    bit haveAccept = 0, haveDone = 0;
    logic prevOv = 1'b0, prevIr = 1'b0;
    logic [CW-1:0]   outLog[$];
    logic [2:0]      rotLog[$];
    logic [4*CW-1:0] bfLog[$];

    always @(negedge clk) begin
        logic [4*CW-1:0] expBf;
        logic [4*CW-1:0] nextBf;
        cyc++;
        if (rst) begin
            mPhase = 0; mLoadN = 0; mCalcN = 0; mOutN = 0;
            haveAccept = 0; haveDone = 0;
        end
        expBf = '0;
        if (mPhase == 1) begin
            for (int j = 0; j < 4; j++) expBf[CW*j +: CW] = mMem[laneAddr(mCalcN, j)];
        end
        checkOutput("in_ready", in_ready, mPhase == 0);
        checkOutput("out_valid", out_valid, mPhase == 2);
        checkOutput("busy", busy, mPhase != 0);
        checkOutput("bf_rot", bf_rot, (mPhase == 1) ? mCalcN : 0);
        checkOutput("bf_in", bf_in, expBf);
        checkOutput("out_data", out_data, (mPhase == 2) ? mMem[mOutN] : '0);
        checkOutput("frame_done", frame_done, (mPhase == 2) && out_ready && (mOutN == 15));

        if (out_valid && !prevOv && haveAccept) begin
            checkOutput("latency", cyc - lastAcceptCyc, 9);
            haveAccept = 0;
        end
        if (in_ready && !prevIr && haveDone && !rst) begin
            checkOutput("ready_after_done", cyc - lastDoneCyc, 1);
            haveDone = 0;
        end
        if (out_valid && out_ready) outLog.push_back(out_data);
        if (busy && !out_valid) begin
            rotLog.push_back(bf_rot);
            bfLog.push_back(bf_in);
        end
        if (frame_done) begin
            donePulses++;
            lastDoneCyc = cyc;
            haveDone = 1;
        end

        if (!rst) begin
            case (mPhase)
                0: if (in_valid) begin
                    mMem[4*(mLoadN % 4) + mLoadN / 4] = in_data;
                    if (mLoadN == 15) begin
                        mPhase = 1; mLoadN = 0;
                        lastAcceptCyc = cyc; haveAccept = 1;
                    end else mLoadN++;
                end
                1: begin
                    nextBf = stubFn(expBf, 3'(mCalcN), stubMode);
                    for (int j = 0; j < 4; j++) mMem[laneAddr(mCalcN, j)] = nextBf[CW*j +: CW];
                    if (mCalcN == 7) begin mPhase = 2; mCalcN = 0; end
                    else mCalcN++;
                end
                default: if (out_ready) begin
                    if (mOutN == 15) begin mPhase = 0; mOutN = 0; end
                    else mOutN++;
                end
            endcase
        end
        prevOv = out_valid;
        prevIr = in_ready;
    end

    initial begin
        int p = 0;
        forever begin
            @(posedge clk); #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: begin out_ready = (p == 0) || (p == 3); p = (p + 1) % 4; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [CW-1:0] makeSample(input int kind, input int n);
        case (kind)
            0: return {17'(n), 17'd0};
            1: return (n == 0) ? {17'd100, 17'd0} : '0;
            default: return CW'({$urandom(), $urandom()});
        endcase
    endfunction

    task automatic pushSamples(input int count, input int kind, input int validMode);
        int n = 0;
        int guard = 0;
        bit acc;
        while (n < count && guard < 5000) begin
            in_valid = (validMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data  = makeSample(kind, n % 16);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) n++;
            guard++;
        end
        if (n < count) checkOutput("push_timeout", n, count);
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int kind, input int validMode, input int nFrames);
        int target;
        int g = 0;
        target = donePulses + nFrames;
        outLog.delete(); rotLog.delete(); bfLog.delete();
        pushSamples(16*nFrames, kind, validMode);
        while (donePulses < target && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("frame_done_count", donePulses, target);
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_bf_in", bf_in, 0);
        checkOutput("rst_bf_rot", bf_rot, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic checkIdentityFrame();
        int expSeq[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        logic [4*CW-1:0] t;
        stubMode = 0;
        readyMode = 0;
        applyStimulus(0, 0, 1);
        checkOutput("id_out_count", outLog.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < outLog.size()) checkOutput("id_out", outLog[i], {17'(expSeq[i]), 17'd0});
        checkOutput("id_rot_count", rotLog.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < rotLog.size()) checkOutput("id_rot", rotLog[i], i);
        for (int k = 0; k < 4; k++) begin
            if (4 + k < bfLog.size()) begin
                t = bfLog[4 + k];
                for (int j = 0; j < 4; j++) checkOutput("id_stage1_lane", t[CW*j+DW +: DW], 4*k + j);
            end
        end
    endtask

    initial begin
        #20000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_busy", busy, 0);
        rst = 1'b0;

        checkIdentityFrame();

        stubMode = 1;
        readyMode = 0;
        applyStimulus(1, 0, 1);
        checkOutput("imp_out_count", outLog.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < outLog.size()) checkOutput("impulse_out", outLog[i], {17'd100, 17'd0});

        stubMode = 2;
        readyMode = 1;
        applyStimulus(2, 1, 1);
        readyMode = 2;
        applyStimulus(2, 1, 2);
        stubMode = 1;
        applyStimulus(2, 1, 1);

        stubMode = 2;
        readyMode = 0;
        pushSamples(7, 2, 0);
        resetPulse();
        pushSamples(16, 2, 0);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("calc3_rot", bf_rot, 3);
        resetPulse();
        checkIdentityFrame();

        stubMode = 2;
        readyMode = 0;
        applyStimulus(2, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
